// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, receiver FSM encoding and error counter limit.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_ACTIVE    = 480;
  localparam logic VGA_SYNC_POL  = 1'b0;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises one asynchronous sync line and flags its leading (active-going) edge.
module sync_edge_detect
  import vga_timing_pkg::*;
#(
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic sync_in,
  output logic lead
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  // Two-flop synchroniser followed by a history flop; reset parks all three at the
  // active level so a line that is already active at reset release gives no edge.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      meta_reg <= SYNC_POL;
      sync_reg <= SYNC_POL;
      hist_reg <= SYNC_POL;
    end else begin
      meta_reg <= sync_in;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign lead = (sync_reg == SYNC_POL) && (hist_reg != SYNC_POL);

endmodule

// File: rtl/vga_sync_receiver.sv
// Regenerates pixel/line coordinates, active window and lock status from incoming VGA syncs.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter logic SYNC_POL    = VGA_SYNC_POL,
  parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic        active_video,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [15:0] H_MAX   = 16'(2 * H_TOTAL - 1);
  localparam logic [15:0] V_MAX   = 16'(2 * V_TOTAL - 1);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_OFF   = 16'(H_SYNC + H_BP);
  localparam logic [15:0] V_OFF   = 16'(V_SYNC + V_BP);
  localparam logic [15:0] H_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_END   = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic [1:0]  sync_raw;
  logic [1:0]  sync_lead;
  logic        hs_lead, vs_lead;

  logic [15:0] h_cnt_reg, h_cnt_next;
  logic [15:0] v_cnt_reg, v_cnt_next;
  logic        vs_pending_reg, vs_pending_next;
  rx_state_t   state_reg, state_next;
  logic [7:0]  good_cnt_reg, good_cnt_next;
  logic        first_line_reg, first_line_next;
  logic [7:0]  err_count_reg, err_count_next;
  logic        sync_err_reg, sync_err_next;
  logic [15:0] x_pos_reg, y_pos_reg;
  logic        active_video_reg, frame_start_reg;

  logic        frame_bnd, timeout, line_err, frame_err, check_err;
  logic        window_on;

  assign sync_raw = {vsync_in, hsync_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_edge (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .sync_in   (sync_raw[gi]),
        .lead      (sync_lead[gi])
      );
    end
  endgenerate

  assign hs_lead = sync_lead[0];
  assign vs_lead = sync_lead[1];

  // Timing events and violations derived from the current counters and edges.
  always_comb begin
    frame_bnd = hs_lead && (vs_pending_reg || vs_lead);
    timeout   = !hs_lead && (h_cnt_reg == H_MAX);
    line_err  = hs_lead && !first_line_reg && (h_cnt_reg != H_LAST);
    frame_err = frame_bnd && (v_cnt_reg != V_LAST);
    check_err = line_err || frame_err || timeout;
    window_on = (h_cnt_reg >= H_OFF) && (h_cnt_reg < H_END) &&
                (v_cnt_reg >= V_OFF) && (v_cnt_reg < V_END) &&
                (state_reg == LOCKED);
  end

  // Saturating line/frame counters; a vsync edge waits for the next hsync edge to start a frame.
  always_comb begin
    h_cnt_next      = h_cnt_reg;
    v_cnt_next      = v_cnt_reg;
    vs_pending_next = vs_pending_reg;
    if (hs_lead) begin
      h_cnt_next = 16'd0;
    end else if (h_cnt_reg != H_MAX) begin
      h_cnt_next = h_cnt_reg + 16'd1;
    end
    if (vs_lead) begin
      vs_pending_next = 1'b1;
    end
    if (hs_lead) begin
      if (frame_bnd) begin
        v_cnt_next      = 16'd0;
        vs_pending_next = 1'b0;
      end else if (v_cnt_reg != V_MAX) begin
        v_cnt_next = v_cnt_reg + 16'd1;
      end
    end
  end

  // Lock FSM: only errors seen while locked are reported and counted.
  always_comb begin
    state_next      = state_reg;
    good_cnt_next   = good_cnt_reg;
    first_line_next = first_line_reg;
    err_count_next  = err_count_reg;
    sync_err_next   = 1'b0;
    if (hs_lead) begin
      first_line_next = 1'b0;
    end
    case (state_reg)
      SEARCH: begin
        if (frame_bnd) begin
          state_next      = VERIFY;
          good_cnt_next   = 8'd0;
          first_line_next = 1'b1;
        end
      end
      VERIFY: begin
        if (check_err) begin
          state_next = SEARCH;
        end else if (frame_bnd) begin
          good_cnt_next = good_cnt_reg + 8'd1;
          if (good_cnt_next >= LOCK_N) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (check_err) begin
          state_next    = SEARCH;
          sync_err_next = 1'b1;
          if (err_count_reg != ERR_COUNT_MAX) begin
            err_count_next = err_count_reg + 8'd1;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // State, counters and registered outputs (coordinates lag the counters by one clock).
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      h_cnt_reg        <= 16'd0;
      v_cnt_reg        <= 16'd0;
      vs_pending_reg   <= 1'b0;
      state_reg        <= SEARCH;
      good_cnt_reg     <= 8'd0;
      first_line_reg   <= 1'b0;
      err_count_reg    <= 8'd0;
      sync_err_reg     <= 1'b0;
      frame_start_reg  <= 1'b0;
      x_pos_reg        <= 16'd0;
      y_pos_reg        <= 16'd0;
      active_video_reg <= 1'b0;
    end else begin
      h_cnt_reg        <= h_cnt_next;
      v_cnt_reg        <= v_cnt_next;
      vs_pending_reg   <= vs_pending_next;
      state_reg        <= state_next;
      good_cnt_reg     <= good_cnt_next;
      first_line_reg   <= first_line_next;
      err_count_reg    <= err_count_next;
      sync_err_reg     <= sync_err_next;
      frame_start_reg  <= frame_bnd;
      x_pos_reg        <= window_on ? (h_cnt_reg - H_OFF) : 16'd0;
      y_pos_reg        <= window_on ? (v_cnt_reg - V_OFF) : 16'd0;
      active_video_reg <= window_on;
    end
  end

  assign x_pos        = x_pos_reg;
  assign y_pos        = y_pos_reg;
  assign active_video = active_video_reg;
  assign frame_start  = frame_start_reg;
  assign locked       = (state_reg == LOCKED);
  assign sync_err     = sync_err_reg;
  assign err_count    = err_count_reg;

endmodule
